param_counter: RTL and testbench
================================

// Module: param_counter
// PURPOSE
//  Parametrised successor of the 4-bit mode counter: WIDTH-bit counter with four modes,
//  programmable terminal value (modulo-(top+1) counting), optional saturation, and
//  registered rco/load flags. Drop-in replacement for counter in the scoreboard bench.
// PARAMETERS
//  WIDTH     4   counter width in bits (>=2)
//  STEP      3   increment used in mode 2'b10 (1 <= STEP <= 2^WIDTH-1)
//  SATURATE  0   0: wrap at bounds; 1: hold at bound instead of wrapping
// PORTS
//  clk     in   1      single clock, all state on rising edge
//  reset   in   1      asynchronous, active-low (reset==0 clears state immediately)
//  enable  in   1      1: count/load per mode; 0: hold Q
//  mode    in   2      00 up+1, 01 down-1, 10 up+STEP, 11 load D
//  D       in   WIDTH  load value for mode 11
//  top     in   WIDTH  terminal value; legal range of Q is 0..top
//  Q       out  WIDTH  registered count
//  rco     out  1      registered; 1 for the cycle following a wrap/saturation event
//  load    out  1      registered; 1 for the cycle following a mode-11 load
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert in use): Q=0, rco=0, load=0.
//  - enable=0: Q holds; rco=0, load=0 on next edge. mode/D/top ignored.
//  - Latency: one edge; Q, rco, load all update together at the same edge.
//  - Arithmetic done in WIDTH+1 bits; no silent truncation.
//  - 00 up: Q==top -> Q=0 (SATURATE=0) or Q=top (SATURATE=1), rco=1; else Q+1, rco=0.
//  - 01 down: Q==0 -> Q=top (SATURATE=0) or Q=0 (SATURATE=1), rco=1; else Q-1, rco=0.
//  - 10 step: s=Q+STEP; s>top -> Q=s-(top+1) (SATURATE=0) or Q=top (SATURATE=1), rco=1;
//    else Q=s, rco=0. If STEP>top+1 with SATURATE=0, result reduced mod (top+1).
//  - 11 load: Q = (D>top) ? top : D; load=1; rco=0.
//  - Saturated: rco=1 on every enabled edge that attempts to pass the bound.
//  - Q>top (top lowered mid-count): next counting edge treats it as wrap event:
//    up/step -> Q=0 (wrap) or top (sat), rco=1; down -> Q=min(Q-1,top), rco=0.
//  - top==0: up/down/step keep Q=0 and assert rco every enabled edge.
//  - reset asserted mid-operation: outputs clear asynchronously, no stale rco/load.
//  - mode/D/top sampled only at rising clk; X on mode while enable=1 is illegal.
// STRUCTURE
//  - Header counter_defs.vh: `define MODE_UP 2'b00, MODE_DN 2'b01, MODE_STEP 2'b10,
//    MODE_LOAD 2'b11; shared by RTL, driver and checker.
//  - One sub-module: counter_next (combinational) -> {q_next, rco_next, load_next}
//    from Q, mode, D, top, enable; param_counter keeps only the three registers.
//  - Synthesisable with the cmos_cells flow; no latches, no initial blocks in RTL.
// TESTING
//  - reset=0 pulse mid-count at Q=5 -> Q=0, rco=0, load=0 before next clk edge.
//  - WIDTH=4, top=9, mode 00 from 0, 12 edges -> Q 1..9,0,1,2; rco=1 only after 9->0.
//  - mode 01 from Q=1, top=9 -> Q 0, then 9 with rco=1; SATURATE=1 -> Q stays 0, rco=1 each edge.
//  - mode 10, STEP=3, top=15, Q=14 -> Q=1, rco=1; SATURATE=1 -> Q=15, rco=1.
//  - mode 11, D=12, top=9 -> Q=9, load=1 one cycle; D=4 -> Q=4, load=1; enable=0 -> hold, flags 0.
//  - Lower top from 15 to 5 at Q=12, mode 00 -> Q=0, rco=1; random 1000-cycle run vs checker model.

Source files
------------

// File: rtl/param_counter_pkg.sv
// Shared definitions for the parametrised mode counter: mode encodings
// used by the RTL and by anything that drives or checks the counter.
package param_counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP   = 2'b00;  // count up by one
    localparam mode_t MODE_DN   = 2'b01;  // count down by one
    localparam mode_t MODE_STEP = 2'b10;  // count up by STEP
    localparam mode_t MODE_LOAD = 2'b11;  // load D, clipped to top

endpackage

// File: rtl/param_counter_next.sv
// Combinational next-state logic for param_counter. Computes the next count
// and the two event flags from the current count and the sampled controls.
// All comparisons and sums are done one bit wider than the count so that
// Q+STEP and top+1 never overflow.
module param_counter_next
    import param_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] top,
    input  logic             enable,
    output logic [WIDTH-1:0] q_next,
    output logic             rco_next,
    output logic             load_next
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] top_ext;
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] mod_ext;
    logic [WIDTH:0] wrap_ext;

    assign q_ext    = {1'b0, q};
    assign top_ext  = {1'b0, top};
    assign sum_ext  = q_ext + STEP_EXT;
    // Modulus top+1 is never zero in WIDTH+1 bits.
    assign mod_ext  = top_ext + (WIDTH+1)'(1);
    // A step larger than top+1 can overshoot by more than one period, so
    // reduce fully instead of subtracting once.
    assign wrap_ext = sum_ext % mod_ext;

    // Mode decode: default is hold with both flags cleared.
    always_comb begin
        q_next    = q;
        rco_next  = 1'b0;
        load_next = 1'b0;
        if (enable) begin
            case (mode)
                MODE_UP: begin
                    // q above top (top lowered mid-count) is treated as a wrap.
                    if (q_ext >= top_ext) begin
                        q_next   = (SATURATE != 0) ? top : '0;
                        rco_next = 1'b1;
                    end else begin
                        q_next = q + WIDTH'(1);
                    end
                end
                MODE_DN: begin
                    if (q == '0) begin
                        q_next   = (SATURATE != 0) ? '0 : top;
                        rco_next = 1'b1;
                    end else if (q_ext > top_ext) begin
                        // min(q-1, top) is always top when q > top.
                        q_next = top;
                    end else begin
                        q_next = q - WIDTH'(1);
                    end
                end
                MODE_STEP: begin
                    if (q_ext > top_ext) begin
                        q_next   = (SATURATE != 0) ? top : '0;
                        rco_next = 1'b1;
                    end else if (sum_ext > top_ext) begin
                        q_next   = (SATURATE != 0) ? top : WIDTH'(wrap_ext);
                        rco_next = 1'b1;
                    end else begin
                        q_next = WIDTH'(sum_ext);
                    end
                end
                MODE_LOAD: begin
                    q_next    = (d > top) ? top : d;
                    load_next = 1'b1;
                end
                default: begin
                    q_next = q;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_counter.sv
// WIDTH-bit four-mode counter with programmable terminal value, optional
// saturation and registered wrap (rco) and load flags. Holds only the
// state registers; all decisions live in param_counter_next.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load
);

    logic [WIDTH-1:0] q_reg;
    logic             rco_reg;
    logic             load_reg;
    logic [WIDTH-1:0] q_next;
    logic             rco_next;
    logic             load_next;

    param_counter_next #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_next (
        .q         (q_reg),
        .mode      (mode),
        .d         (D),
        .top       (top),
        .enable    (enable),
        .q_next    (q_next),
        .rco_next  (rco_next),
        .load_next (load_next)
    );

    // Count and flag registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg    <= '0;
            rco_reg  <= 1'b0;
            load_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            rco_reg  <= rco_next;
            load_reg <= load_next;
        end
    end

    assign Q    = q_reg;
    assign rco  = rco_reg;
    assign load = load_reg;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: one wrapping and one saturating instance
// share the same stimulus; every step checks both against hand-worked values.
module tb_param_counter;
    import param_counter_pkg::*;

    logic       clk;
    logic       reset;
    logic       enable;
    mode_t      mode;
    logic [3:0] d;
    logic [3:0] top;
    logic [3:0] q_w, q_s;
    logic       rco_w, rco_s, load_w, load_s;

    int checks = 0;
    int errors = 0;

    // Expected sequences for 12 up-count edges from 0 with top=9.
    int up_w [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_s [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};

    param_counter #(.WIDTH(4), .STEP(3), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(d), .top(top),
        .Q(q_w), .rco(rco_w), .load(load_w)
    );

    param_counter #(.WIDTH(4), .STEP(3), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(d), .top(top),
        .Q(q_s), .rco(rco_s), .load(load_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic expect6(input string tag,
                           input int qw, input int rw, input int lw,
                           input int qs, input int rs, input int ls);
        chk({tag, ".Qw"},    {28'b0, q_w},    32'(qw));
        chk({tag, ".rcow"},  {31'b0, rco_w},  32'(rw));
        chk({tag, ".loadw"}, {31'b0, load_w}, 32'(lw));
        chk({tag, ".Qs"},    {28'b0, q_s},    32'(qs));
        chk({tag, ".rcos"},  {31'b0, rco_s},  32'(rs));
        chk({tag, ".loads"}, {31'b0, load_s}, 32'(ls));
        $display("step %-12s Qw=%0d rcow=%0b loadw=%0b Qs=%0d rcos=%0b loads=%0b",
                 tag, q_w, rco_w, load_w, q_s, rco_s, load_s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        mode   = MODE_UP;
        d      = 4'd0;
        top    = 4'd9;
        #2;
        expect6("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Up count through the terminal value.
        enable = 1'b1; mode = MODE_LOAD; d = 4'd0;
        tick(); expect6("ld0", 0, 0, 1, 0, 0, 1);
        mode = MODE_UP;
        for (int i = 0; i < 12; i++) begin
            tick();
            expect6($sformatf("up%0d", i), up_w[i], (i == 9) ? 1 : 0, 0,
                    up_s[i], (i >= 9) ? 1 : 0, 0);
        end

        // Down count through zero.
        mode = MODE_LOAD; d = 4'd1;
        tick(); expect6("ld1", 1, 0, 1, 1, 0, 1);
        mode = MODE_DN;
        tick(); expect6("dn1", 0, 0, 0, 0, 0, 0);
        tick(); expect6("dn_wrap", 9, 1, 0, 0, 1, 0);
        tick(); expect6("dn_after", 8, 0, 0, 0, 1, 0);

        // Step past top=15.
        top = 4'd15; mode = MODE_LOAD; d = 4'd14;
        tick(); expect6("ld14", 14, 0, 1, 14, 0, 1);
        mode = MODE_STEP;
        tick(); expect6("step_wrap", 1, 1, 0, 15, 1, 0);
        enable = 1'b0;
        tick(); expect6("hold_rco", 1, 0, 0, 15, 0, 0);

        // Load clipping and hold with controls changing underneath.
        enable = 1'b1; top = 4'd9; mode = MODE_LOAD; d = 4'd12;
        tick(); expect6("ld_clip", 9, 0, 1, 9, 0, 1);
        d = 4'd4;
        tick(); expect6("ld4", 4, 0, 1, 4, 0, 1);
        enable = 1'b0; mode = MODE_UP; d = 4'd7; top = 4'd0;
        tick(); expect6("hold_ld", 4, 0, 0, 4, 0, 0);

        // Top lowered below the current count.
        enable = 1'b1; top = 4'd15; mode = MODE_LOAD; d = 4'd12;
        tick(); expect6("ld12a", 12, 0, 1, 12, 0, 1);
        top = 4'd5; mode = MODE_UP;
        tick(); expect6("toplow_up", 0, 1, 0, 5, 1, 0);
        top = 4'd15; mode = MODE_LOAD; d = 4'd12;
        tick(); expect6("ld12b", 12, 0, 1, 12, 0, 1);
        top = 4'd5; mode = MODE_DN;
        tick(); expect6("toplow_dn", 5, 0, 0, 5, 0, 0);

        // top == 0: every counting edge is a bound event.
        top = 4'd0; mode = MODE_UP;
        tick(); expect6("top0_up", 0, 1, 0, 0, 1, 0);
        mode = MODE_DN;
        tick(); expect6("top0_dn", 0, 1, 0, 0, 1, 0);
        mode = MODE_STEP;
        tick(); expect6("top0_step", 0, 1, 0, 0, 1, 0);

        // STEP larger than top+1 reduces modulo (top+1).
        top = 4'd1; mode = MODE_LOAD; d = 4'd1;
        tick(); expect6("ld_t1", 1, 0, 1, 1, 0, 1);
        mode = MODE_STEP;
        tick(); expect6("bigstep1", 0, 1, 0, 1, 1, 0);
        tick(); expect6("bigstep2", 1, 1, 0, 1, 1, 0);

        // Plain step without reaching top.
        top = 4'd15; mode = MODE_LOAD; d = 4'd2;
        tick(); expect6("ld2", 2, 0, 1, 2, 0, 1);
        mode = MODE_STEP;
        tick(); expect6("step", 5, 0, 0, 5, 0, 0);

        // Asynchronous reset pulse with a pending load flag.
        top = 4'd9; mode = MODE_LOAD; d = 4'd5;
        tick(); expect6("ld5", 5, 0, 1, 5, 0, 1);
        mode = MODE_UP;
        #2;
        reset = 1'b0;
        #1;
        expect6("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        expect6("rst_held", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(); expect6("post_rst", 1, 0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
